maze_game_ctrl: RTL and testbench
=================================

// Module: maze_game_ctrl
// PURPOSE
//  Parametrised maze-game controller: menu/difficulty select, timed map preview, player movement
//  with wall collision against a row-organised map ROM, lives, and win/lose detection.
//  Sits between the button conditioners (single-cycle pulses) and the VGA renderer.
//  The renderer reads player position, show_map and state; the map ROM is read through map_addr/map_row.
// PARAMETERS
//  MAP_W       30       map columns; bits per ROM row; bit x = 1 means wall at column x
//  MAP_H       21       map rows; ROM depth
//  START_X     0        player start column
//  START_Y     20       player start row
//  GOAL_X      29       goal column
//  GOAL_Y      0        goal row
//  LIVES       3        collisions allowed before loss (1..7)
//  SHOW_TICKS  1000000  easy-mode preview length in clk cycles (max 2^32-1)
// PORTS
//  clk         in   1            system clock
//  reset       in   1            synchronous, active-high
//  btn         in   4            single-cycle pulses: [0] up, [1] down, [2] left, [3] right
//  btn_sel     in   1            single-cycle select pulse
//  map_row     in   MAP_W        ROM data; valid 1 cycle after map_addr is registered
//  map_addr    out  clog2(MAP_H) ROM row address (registered)
//  player_x    out  clog2(MAP_W) player column
//  player_y    out  clog2(MAP_H) player row
//  difficulty  out  2            0 easy, 1 medium, 2 hard
//  lives       out  3            remaining lives
//  show_map    out  1            1 while the map is shown to the renderer
//  state       out  3            0 MENU, 1 SHOW, 2 PLAY, 3 FETCH, 4 CHECK, 5 LOST, 6 WON
//  lost, won   out  1 each       high while state is LOST / WON respectively
// BEHAVIOUR
//  Reset: state MENU; difficulty 0; player (START_X, START_Y); lives LIVES; map_addr 0; show_map, lost, won 0.
//  MENU: btn[2] decrements difficulty and btn[3] increments it, both wrapping within 0..2.
//   btn_sel: player goes to start, lives loads LIVES, timer loads SHOW_TICKS >> difficulty, next state SHOW.
//  SHOW: show_map=1. Timer decrements each cycle; when it equals 0, next state PLAY (preview = load+1 cycles).
//   All buttons are ignored.
//  PLAY: show_map=0. At most one move is accepted per cycle.
//   If several btn bits are high together, priority is up > down > left > right.
//   Target is the player position ±1 on one axis. A move off the map edge (y=0 up, y=MAP_H-1 down,
//   x=0 left, x=MAP_W-1 right) is discarded: no ROM access, state stays PLAY.
//   Otherwise the target is latched, map_addr <= target_y, next state FETCH.
//  FETCH: 1-cycle ROM latency wait; next state CHECK. Buttons are ignored.
//  CHECK: map_row[target_x] is sampled.
//   Wall: position is unchanged and lives decrements. If lives becomes 0, next state LOST.
//    Otherwise the timer reloads to SHOW_TICKS >> (difficulty+1) and next state is SHOW (penalty re-preview).
//   Free: player takes the target. If the target equals (GOAL_X, GOAL_Y), next state WON, else PLAY.
//   Move latency: button pulse -> position update is 3 cycles (PLAY, FETCH, CHECK).
//  LOST/WON: the matching flag is high and show_map=1. btn_sel returns to MENU and clears the flags.
//   Difficulty is kept; the other buttons are ignored.
//  Reset asserted in any state, including mid-FETCH/CHECK, forces the reset values on the next edge.
//   A pending move is dropped.
//  btn_sel is ignored outside MENU/LOST/WON; btn is ignored outside MENU/PLAY.
// TESTING
//  T1 reset, 3x btn[3] in MENU -> difficulty 1,2,0 (wrap); btn[2] at 0 -> difficulty 2.
//  T2 SHOW_TICKS=8, difficulty 1, btn_sel -> show_map high exactly 5 cycles, then state PLAY.
//  T3 player (0,20): btn[2] -> discarded, map_addr unchanged. btn[0] into free cell -> player_y=19
//     3 cycles later. btn[0]|btn[3] in the same cycle -> up taken.
//  T4 wall at (0,19), LIVES=2: btn[0] -> lives 1, position kept, state SHOW. Repeat -> lives 0, lost=1.
//  T5 open path to goal -> won=1 on the goal-entering CHECK; btn_sel -> MENU, won=0, difficulty kept.
//  T6 reset asserted during FETCH -> next cycle state MENU, player (START_X, START_Y), lives LIVES.

Source files
------------

// File: rtl/maze_game_ctrl.sv
// Maze-game controller: difficulty menu, timed map preview, ROM-checked player moves,
// lives and win/lose detection. All outputs are registered.
module maze_game_ctrl #(
  parameter int unsigned MAP_W      = 30,
  parameter int unsigned MAP_H      = 21,
  parameter int unsigned START_X    = 0,
  parameter int unsigned START_Y    = 20,
  parameter int unsigned GOAL_X     = 29,
  parameter int unsigned GOAL_Y     = 0,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned SHOW_TICKS = 1000000,
  localparam int unsigned XW = (MAP_W > 1) ? $clog2(MAP_W) : 1,
  localparam int unsigned YW = (MAP_H > 1) ? $clog2(MAP_H) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       btn,
  input  logic             btn_sel,
  input  logic [MAP_W-1:0] map_row,
  output logic [YW-1:0]    map_addr,
  output logic [XW-1:0]    player_x,
  output logic [YW-1:0]    player_y,
  output logic [1:0]       difficulty,
  output logic [2:0]       lives,
  output logic             show_map,
  output logic [2:0]       state,
  output logic             lost,
  output logic             won
);

  localparam int unsigned TW = 32;

  localparam logic [2:0] S_MENU  = 3'd0;
  localparam logic [2:0] S_SHOW  = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_LOST  = 3'd5;
  localparam logic [2:0] S_WON   = 3'd6;

  localparam logic [XW-1:0] START_XV = XW'(START_X);
  localparam logic [YW-1:0] START_YV = YW'(START_Y);
  localparam logic [XW-1:0] GOAL_XV  = XW'(GOAL_X);
  localparam logic [YW-1:0] GOAL_YV  = YW'(GOAL_Y);
  localparam logic [XW-1:0] LAST_X   = XW'(MAP_W - 1);
  localparam logic [YW-1:0] LAST_Y   = YW'(MAP_H - 1);
  localparam logic [2:0]    LIVES_V  = 3'(LIVES);
  localparam logic [TW-1:0] TICKS_V  = TW'(SHOW_TICKS);

  logic [XW-1:0] target_x;
  logic [YW-1:0] target_y;
  logic [TW-1:0] timer;

  logic [2:0]    state_n;
  logic [1:0]    diff_n;
  logic [XW-1:0] px_n;
  logic [YW-1:0] py_n;
  logic [2:0]    lives_n;
  logic [YW-1:0] addr_n;
  logic [XW-1:0] tx_n;
  logic [YW-1:0] ty_n;
  logic [TW-1:0] timer_n;
  logic          show_n;
  logic          lost_n;
  logic          won_n;

  // Candidate move in PLAY: first set button wins, edge moves are rejected
  logic          mv_ok;
  logic [XW-1:0] mv_x;
  logic [YW-1:0] mv_y;

  always_comb begin
    mv_ok = 1'b0;
    mv_x  = player_x;
    mv_y  = player_y;
    if (btn[0]) begin
      mv_ok = (player_y != '0);
      mv_y  = player_y - YW'(1);
    end else if (btn[1]) begin
      mv_ok = (player_y != LAST_Y);
      mv_y  = player_y + YW'(1);
    end else if (btn[2]) begin
      mv_ok = (player_x != '0);
      mv_x  = player_x - XW'(1);
    end else if (btn[3]) begin
      mv_ok = (player_x != LAST_X);
      mv_x  = player_x + XW'(1);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    diff_n  = difficulty;
    px_n    = player_x;
    py_n    = player_y;
    lives_n = lives;
    addr_n  = map_addr;
    tx_n    = target_x;
    ty_n    = target_y;
    timer_n = timer;

    case (state)
      S_MENU: begin
        if (btn_sel) begin
          px_n    = START_XV;
          py_n    = START_YV;
          lives_n = LIVES_V;
          timer_n = TICKS_V >> difficulty;
          state_n = S_SHOW;
        end else if (btn[2]) begin
          diff_n = (difficulty == 2'd0) ? 2'd2 : difficulty - 2'd1;
        end else if (btn[3]) begin
          diff_n = (difficulty >= 2'd2) ? 2'd0 : difficulty + 2'd1;
        end
      end
      S_SHOW: begin
        if (timer == '0) begin
          state_n = S_PLAY;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      S_PLAY: begin
        if (mv_ok) begin
          tx_n    = mv_x;
          ty_n    = mv_y;
          addr_n  = mv_y;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        state_n = S_CHECK;
      end
      S_CHECK: begin
        if (map_row[target_x]) begin
          lives_n = lives - 3'd1;
          if (lives <= 3'd1) begin
            state_n = S_LOST;
          end else begin
            // Penalty preview is half the difficulty's normal preview
            timer_n = TICKS_V >> ({1'b0, difficulty} + 3'd1);
            state_n = S_SHOW;
          end
        end else begin
          px_n = target_x;
          py_n = target_y;
          if (target_x == GOAL_XV && target_y == GOAL_YV) begin
            state_n = S_WON;
          end else begin
            state_n = S_PLAY;
          end
        end
      end
      S_LOST, S_WON: begin
        if (btn_sel) begin
          state_n = S_MENU;
        end
      end
      default: begin
        state_n = S_MENU;
      end
    endcase

    show_n = (state_n == S_SHOW) || (state_n == S_LOST) || (state_n == S_WON);
    lost_n = (state_n == S_LOST);
    won_n  = (state_n == S_WON);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_MENU;
      difficulty <= 2'd0;
      player_x   <= START_XV;
      player_y   <= START_YV;
      lives      <= LIVES_V;
      map_addr   <= '0;
      target_x   <= '0;
      target_y   <= '0;
      timer      <= '0;
      show_map   <= 1'b0;
      lost       <= 1'b0;
      won        <= 1'b0;
    end else begin
      state      <= state_n;
      difficulty <= diff_n;
      player_x   <= px_n;
      player_y   <= py_n;
      lives      <= lives_n;
      map_addr   <= addr_n;
      target_x   <= tx_n;
      target_y   <= ty_n;
      timer      <= timer_n;
      show_map   <= show_n;
      lost       <= lost_n;
      won        <= won_n;
    end
  end

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Bench for maze_game_ctrl: directed scenarios plus random moves over random maps,
// checked against a coordinate-level game model through an expectation queue.
module tb_maze_game_ctrl;

  localparam int MAP_W      = 30;
  localparam int MAP_H      = 21;
  localparam int START_X    = 0;
  localparam int START_Y    = 20;
  localparam int GOAL_X     = 29;
  localparam int GOAL_Y     = 0;
  localparam int LIVES      = 2;
  localparam int SHOW_TICKS = 8;

  localparam logic [2:0] ST_MENU  = 3'd0;
  localparam logic [2:0] ST_SHOW  = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_LOST  = 3'd5;
  localparam logic [2:0] ST_WON   = 3'd6;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] lv;
    logic [2:0] st;
    logic [4:0] addr;
    logic       lost;
    logic       won;
    logic       show;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       btn = '0;
  logic             btn_sel = 1'b0;
  logic [MAP_W-1:0] map_row = '0;
  logic [4:0]       map_addr;
  logic [4:0]       player_x;
  logic [4:0]       player_y;
  logic [1:0]       difficulty;
  logic [2:0]       lives;
  logic             show_map;
  logic [2:0]       state;
  logic             lost;
  logic             won;

  logic [MAP_W-1:0] rom [MAP_H];
  exp_t             exp_q [$];
  int               n_tests = 0;
  int               n_fail = 0;

  int               m_x, m_y, m_lives, m_diff, m_addr;
  logic [2:0]       m_st;

  maze_game_ctrl #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .START_X(START_X), .START_Y(START_Y),
    .GOAL_X(GOAL_X), .GOAL_Y(GOAL_Y), .LIVES(LIVES), .SHOW_TICKS(SHOW_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .btn_sel(btn_sel), .map_row(map_row),
    .map_addr(map_addr), .player_x(player_x), .player_y(player_y),
    .difficulty(difficulty), .lives(lives), .show_map(show_map), .state(state),
    .lost(lost), .won(won)
  );

  always #5 clk = ~clk;

  // Synchronous map ROM, one cycle read latency
  always @(posedge clk) map_row <= rom[map_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic shows(input logic [2:0] st);
    return (st == ST_SHOW) || (st == ST_LOST) || (st == ST_WON);
  endfunction

  // Result of every accepted move appears the cycle after the DUT sits in CHECK
  bit   mon_pend = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_pend) begin
      mon_pend = 1'b0;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_check: got a CHECK result with 0 expectations queued, expected none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("mv_x", player_x, mon_e.x);
        chk("mv_y", player_y, mon_e.y);
        chk("mv_lives", lives, mon_e.lv);
        chk("mv_state", state, mon_e.st);
        chk("mv_addr", map_addr, mon_e.addr);
        chk("mv_lost", lost, mon_e.lost);
        chk("mv_won", won, mon_e.won);
        chk("mv_show", show_map, mon_e.show);
      end
    end
    if (!reset && state == ST_CHECK) mon_pend = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_lives = LIVES; m_diff = 0; m_addr = 0; m_st = ST_MENU;
  endtask

  task automatic check_all(input string name);
    chk({name, "_state"}, state, m_st);
    chk({name, "_x"}, player_x, m_x);
    chk({name, "_y"}, player_y, m_y);
    chk({name, "_lives"}, lives, m_lives);
    chk({name, "_diff"}, difficulty, m_diff);
    chk({name, "_addr"}, map_addr, m_addr);
    chk({name, "_show"}, show_map, shows(m_st));
    chk({name, "_lost"}, lost, m_st == ST_LOST);
    chk({name, "_won"}, won, m_st == ST_WON);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    model_reset();
    check_all("reset");
    reset = 1'b0;
  endtask

  task automatic menu_btn(input logic [3:0] b);
    btn = b;
    tick();
    btn = '0;
    if (b[2]) m_diff = (m_diff + 2) % 3;
    else if (b[3]) m_diff = (m_diff + 1) % 3;
    chk("menu_diff", difficulty, m_diff);
  endtask

  task automatic measure_show(input string name, input int expected);
    int n = 0;
    while (show_map === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk(name, n, expected);
    chk({name, "_then_play"}, state, ST_PLAY);
  endtask

  task automatic start_game();
    btn_sel = 1'b1;
    tick();
    btn_sel = 1'b0;
    m_x = START_X; m_y = START_Y; m_lives = LIVES;
    measure_show("preview_len", (SHOW_TICKS >> m_diff) + 1);
    m_st = ST_PLAY;
  endtask

  task automatic end_to_menu();
    chk("end_lost", lost, m_st == ST_LOST);
    chk("end_won", won, m_st == ST_WON);
    btn_sel = 1'b1;
    tick();
    btn_sel = 1'b0;
    m_st = ST_MENU;
    check_all("to_menu");
  endtask

  task automatic do_move(input logic [3:0] b, input bit noise);
    int   dir, tx, ty;
    bit   acc;
    exp_t e;
    dir = 0;
    for (int i = 3; i >= 0; i--) if (b[i]) dir = i;
    tx = m_x;
    ty = m_y;
    case (dir)
      0: ty = ty - 1;
      1: ty = ty + 1;
      2: tx = tx - 1;
      default: tx = tx + 1;
    endcase
    acc = (tx >= 0) && (tx < MAP_W) && (ty >= 0) && (ty < MAP_H);
    if (acc) begin
      m_addr = ty;
      if (rom[ty][tx]) begin
        m_lives = m_lives - 1;
        m_st = (m_lives == 0) ? ST_LOST : ST_SHOW;
      end else begin
        m_x = tx;
        m_y = ty;
        m_st = (tx == GOAL_X && ty == GOAL_Y) ? ST_WON : ST_PLAY;
      end
      e.x = 5'(m_x); e.y = 5'(m_y); e.lv = 3'(m_lives); e.st = m_st; e.addr = 5'(m_addr);
      e.lost = (m_st == ST_LOST); e.won = (m_st == ST_WON); e.show = shows(m_st);
      exp_q.push_back(e);
    end
    btn = b;
    tick();
    // Stray presses while the move is in flight must be ignored
    for (int k = 0; k < 2; k++) begin
      btn = (acc && noise) ? 4'($urandom) : 4'b0;
      btn_sel = (acc && noise) ? 1'($urandom) : 1'b0;
      tick();
    end
    btn = '0;
    btn_sel = 1'b0;
    if (!acc) begin
      chk("discard_state", state, ST_PLAY);
      chk("discard_x", player_x, m_x);
      chk("discard_y", player_y, m_y);
      chk("discard_addr", map_addr, m_addr);
    end else if (m_st == ST_SHOW) begin
      measure_show("penalty_len", (SHOW_TICKS >> (m_diff + 1)) + 1);
      m_st = ST_PLAY;
    end
  endtask

  initial begin
    logic [3:0] b;
    for (int r = 0; r < MAP_H; r++) rom[r] = '0;
    model_reset();
    tick();
    apply_reset();
    tick();
    check_all("idle");

    // Difficulty wrap in both directions
    menu_btn(4'b1000);
    menu_btn(4'b1000);
    menu_btn(4'b1000);
    menu_btn(4'b0100);
    menu_btn(4'b0100);

    // Preview at difficulty 1, then edge discard, plain move and priority
    start_game();
    do_move(4'b0100, 1'b0);
    do_move(4'b0001, 1'b0);
    do_move(4'b1001, 1'b1);

    // Wall hits until lives run out
    apply_reset();
    rom[19][0] = 1'b1;
    start_game();
    do_move(4'b0001, 1'b0);
    do_move(4'b0001, 1'b0);
    chk("lost_flag", lost, 1'b1);
    end_to_menu();

    // Clear path to the goal at difficulty 2
    rom[19][0] = 1'b0;
    menu_btn(4'b0100);
    start_game();
    for (int i = 0; i < START_Y - GOAL_Y; i++) do_move(4'b0001, 1'b1);
    for (int i = 0; i < GOAL_X - START_X; i++) do_move(4'b1000, 1'b1);
    chk("won_flag", won, 1'b1);
    end_to_menu();

    // Reset while a move is waiting on the ROM
    start_game();
    btn = 4'b0001;
    tick();
    btn = '0;
    chk("in_fetch", state, ST_FETCH);
    reset = 1'b1;
    tick();
    model_reset();
    check_all("reset_mid_fetch");
    reset = 1'b0;

    // Random moves over random maps
    for (int it = 0; it < 300; it++) begin
      if (m_st == ST_LOST || m_st == ST_WON) end_to_menu();
      if (m_st == ST_MENU) begin
        repeat ($urandom_range(0, 3)) menu_btn($urandom_range(0, 1) ? 4'b1000 : 4'b0100);
        for (int r = 0; r < MAP_H; r++) rom[r] = MAP_W'($urandom) & MAP_W'($urandom);
        rom[START_Y][START_X] = 1'b0;
        start_game();
      end
      b = $urandom_range(0, 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(1, 15));
      do_move(b, 1'b1);
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
